stopwatch_ctrl: RTL and testbench

Control unit for the stopwatch datapath. It conditions three raw push-buttons (run/stop, clear, lap) with a synchronizer, a debouncer and a rising-edge detector each. A Moore FSM uses the resulting pulses to generate the datapath's run and clear levels. It also freezes a lap snapshot of the datapath time outputs, and drives a registered time bus for the display, selecting either the live time or the lap time.

---
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the stopwatch buttons and sequences run/clear/lap for the datapath and display.
module stopwatch_ctrl_btn #(
    parameter int DEBOUNCE_CNT = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[0], btn};
        db_d    = db_q;
        cnt_d   = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == LAST) db_d = sync_q[1];
            else cnt_d = cnt_q + 1'b1;
        end
        pulse_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CNT = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_minute,
    input  logic [4:0] i_hour,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap_active,
    output logic [1:0] o_state,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_minute,
    output logic [4:0] o_hour
);
    localparam logic [1:0] STOP  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;

    logic        p_rs, p_cl, p_lap;
    logic        rs, cl, lp;
    logic [1:0]  state_q, state_d;
    logic        lap_active_q, lap_active_d;
    logic [23:0] lap_q, lap_d, disp_q, disp_d, live;

    stopwatch_ctrl_btn #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_rs  (.clk(clk), .reset(reset), .btn(btn_run_stop), .pulse(p_rs));
    stopwatch_ctrl_btn #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_cl  (.clk(clk), .reset(reset), .btn(btn_clear),    .pulse(p_cl));
    stopwatch_ctrl_btn #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_lap (.clk(clk), .reset(reset), .btn(btn_lap),      .pulse(p_lap));

    // Simultaneous pulses collapse to the highest-priority one; the rest are dropped.
    assign rs   = p_rs;
    assign cl   = p_cl & ~p_rs;
    assign lp   = p_lap & ~p_rs & ~p_cl;
    assign live = {i_msec, i_sec, i_minute, i_hour};

    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        lap_d        = lap_q;
        case (state_q)
            STOP: begin
                if (rs) state_d = RUN;
                else if (cl) begin
                    state_d      = CLEAR;
                    lap_active_d = 1'b0;
                    lap_d        = '0;
                end else if (lp) lap_active_d = 1'b0;
            end
            RUN: begin
                if (rs) state_d = STOP;
                else if (lp) begin
                    lap_active_d = ~lap_active_q;
                    lap_d        = lap_active_q ? lap_q : live;
                end
            end
            default: state_d = STOP;
        endcase
        disp_d = lap_active_q ? lap_q : live;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= STOP;
            lap_active_q <= 1'b0;
            lap_q        <= '0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            lap_active_q <= lap_active_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
        end
    end

    assign o_run        = state_q == RUN;
    assign o_clear      = state_q == CLEAR;
    assign o_state      = state_q;
    assign o_lap_active = lap_active_q;
    assign {o_msec, o_sec, o_minute, o_hour} = disp_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CNT=4.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run_stop, btn_clear, btn_lap;
    logic [6:0] i_msec;
    logic [5:0] i_sec, i_minute;
    logic [4:0] i_hour;
    logic       o_run, o_clear, o_lap_active;
    logic [1:0] o_state;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_minute;
    logic [4:0] o_hour;
    int compared = 0;
    int mismatched = 0;
    int clear_cycles = 0;
    logic seen_bad;

    stopwatch_ctrl #(.DEBOUNCE_CNT(4)) dut (
        .clk(clk), .reset(reset),
        .btn_run_stop(btn_run_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .i_msec(i_msec), .i_sec(i_sec), .i_minute(i_minute), .i_hour(i_hour),
        .o_run(o_run), .o_clear(o_clear), .o_lap_active(o_lap_active), .o_state(o_state),
        .o_msec(o_msec), .o_sec(o_sec), .o_minute(o_minute), .o_hour(o_hour)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset === 1'b1 && o_clear === 1'b1) clear_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] disp();
        return {8'd0, o_msec, o_sec, o_minute, o_hour};
    endfunction

    function automatic logic [31:0] tv(input int ms, input int s, input int m, input int h);
        return {8'd0, 7'(ms), 6'(s), 6'(m), 5'(h)};
    endfunction

    task automatic set_time(input int ms, input int s, input int m, input int h);
        i_msec = 7'(ms); i_sec = 6'(s); i_minute = 6'(m); i_hour = 5'(h);
    endtask

    // Drive buttons {run_stop, clear, lap} and wait until the pulse has reached the FSM.
    task automatic press(input logic [2:0] b);
        {btn_run_stop, btn_clear, btn_lap} = b;
        cyc(7);
    endtask

    task automatic rel();
        {btn_run_stop, btn_clear, btn_lap} = 3'b000;
        cyc(8);
    endtask

    initial begin
        reset = 1'b0;
        {btn_run_stop, btn_clear, btn_lap} = 3'b111;
        set_time(5, 6, 7, 8);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_state", 32'(o_state), 0);
            chk("rst_flags", {29'd0, o_run, o_clear, o_lap_active}, 0);
            chk("rst_disp", disp(), 0);
        end
        reset = 1'b1;
        cyc(6);
        chk("rel_pre_state", 32'(o_state), 0);
        cyc(1);
        chk("rel_state", 32'(o_state), 1);
        chk("rel_run", 32'(o_run), 1);
        chk("rel_disp_live", disp(), tv(5, 6, 7, 8));
        rel();
        chk("rel_hold_state", 32'(o_state), 1);
        chk("rel_no_lap", 32'(o_lap_active), 0);
        press(3'b100);
        chk("stop1", 32'(o_state), 0);
        rel();

        seen_bad = 1'b0;
        for (int g = 0; g < 5; g++) begin
            btn_run_stop = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cyc(1);
                if (o_state !== 2'b00 || o_run !== 1'b0) seen_bad = 1'b1;
            end
            btn_run_stop = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cyc(1);
                if (o_state !== 2'b00 || o_run !== 1'b0) seen_bad = 1'b1;
            end
        end
        cyc(8);
        if (o_state !== 2'b00 || o_run !== 1'b0) seen_bad = 1'b1;
        chk("glitch", 32'(seen_bad), 0);

        press(3'b100);
        chk("run_run", 32'(o_run), 1);
        rel();
        press(3'b010);
        cyc(1);
        chk("run_clear_state", 32'(o_state), 1);
        chk("run_clear_nopulse", 32'(clear_cycles), 0);
        rel();
        press(3'b100);
        chk("stop_run", 32'(o_run), 0);
        rel();
        press(3'b010);
        chk("clr_state", 32'(o_state), 2);
        chk("clr_pulse", 32'(o_clear), 1);
        cyc(1);
        chk("clr_back", 32'(o_state), 0);
        chk("clr_low", 32'(o_clear), 0);
        rel();
        chk("clr_once", 32'(clear_cycles), 1);

        press(3'b100);
        rel();
        set_time(42, 17, 3, 1);
        press(3'b001);
        chk("lap_on", 32'(o_lap_active), 1);
        set_time(50, 30, 10, 5);
        cyc(1);
        chk("lap_frozen", disp(), tv(42, 17, 3, 1));
        set_time(99, 59, 59, 23);
        rel();
        chk("lap_hold", disp(), tv(42, 17, 3, 1));
        press(3'b001);
        chk("lap_off", 32'(o_lap_active), 0);
        chk("lap_off_lag", disp(), tv(42, 17, 3, 1));
        cyc(1);
        chk("lap_live", disp(), tv(99, 59, 59, 23));
        rel();

        set_time(11, 22, 33, 4);
        press(3'b001);
        rel();
        set_time(7, 8, 9, 10);
        press(3'b100);
        cyc(1);
        chk("lapstop_state", 32'(o_state), 0);
        chk("lapstop_active", 32'(o_lap_active), 1);
        chk("lapstop_disp", disp(), tv(11, 22, 33, 4));
        rel();
        press(3'b010);
        chk("lapclr_state", 32'(o_state), 2);
        chk("lapclr_active", 32'(o_lap_active), 0);
        cyc(1);
        chk("lapclr_disp", disp(), tv(7, 8, 9, 10));
        rel();
        chk("lapclr_cnt", 32'(clear_cycles), 2);

        press(3'b110);
        chk("sim_rc_state", 32'(o_state), 1);
        rel();
        chk("sim_rc_noclear", 32'(clear_cycles), 2);
        chk("sim_rc_hold", 32'(o_state), 1);
        press(3'b101);
        chk("sim_rl_state", 32'(o_state), 0);
        chk("sim_rl_lap", 32'(o_lap_active), 0);
        rel();
        chk("sim_rl_lap2", 32'(o_lap_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
